// File: rtl/mismatch_gate_pipe_pkg.sv
// Shared definitions for the pipelined mismatch gate: counter limits,
// a population-count helper and the single-lane gate function.
package mismatch_gate_pkg;

   localparam int          CNT_W_DEFAULT = 16;
   localparam logic [31:0] CNT_MAX       = 32'((64'd1 << CNT_W_DEFAULT) - 64'd1);

   // Largest value a saturating counter of the given width can hold
   function automatic logic [31:0] cnt_max(input int width);
      return 32'((64'd1 << width) - 64'd1);
   endfunction

   // Number of set bits; narrower vectors are zero-extended by the caller
   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) begin
         n = n + 7'(v[i]);
      end
      return n;
   endfunction

   // One lane of the mismatch gate
   function automatic logic mg_f(input logic a, input logic b,
                                 input logic c, input logic d);
      return (a ^ b) & (c | (a ^ d));
   endfunction

endpackage

// File: rtl/mismatch_gate_pipe_stage.sv
// One pipeline register slice with a valid bit and an advance enable.
// Data only reloads when a real beat arrives, so bubbles leave the last
// payload in place and the register does not toggle needlessly.
module mg_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         adv,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic         valid_d, valid_q;
   logic [W-1:0] data_d,  data_q;

   // Next state: take upstream valid on advance, hold everything when stalled
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (adv) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
         end
      end
   end

   // Stage register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/mismatch_gate_pipe.sv
// Two-stage pipelined mismatch gate y = (a^b) & (c | (a^d)) per lane with
// valid/ready flow control.
// Optional feature macro TOGGLE_CNT_EN: builds a saturating counter of
// output bit toggles across accepted output beats, cleared by cnt_clr.
// Without the macro toggle_cnt is tied to zero and cnt_clr is ignored.
module mismatch_gate_pipe
   import mismatch_gate_pkg::*;
#(
   parameter int LANES = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LANES-1:0] a,
   input  logic [LANES-1:0] b,
   input  logic [LANES-1:0] c,
   input  logic [LANES-1:0] d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LANES-1:0] y,
   output logic             any_hit,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] toggle_cnt
);

   logic               s1_valid, s2_valid;
   logic               s1_adv,   s2_adv;
   logic [4*LANES-1:0] s1_data;
   logic [LANES-1:0]   s1_a, s1_b, s1_c, s1_d;
   logic [LANES-1:0]   f;
   logic [LANES:0]     s2_data;

   assign s2_adv   = !s2_valid | out_ready;
   assign s1_adv   = !s1_valid | s2_adv;
   assign in_ready = s1_adv;

   mg_pipe_stage #(.W(4*LANES)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (s1_adv),
      .in_valid  (in_valid),
      .in_data   ({a, b, c, d}),
      .out_valid (s1_valid),
      .out_data  (s1_data)
   );

   assign {s1_a, s1_b, s1_c, s1_d} = s1_data;

   // Evaluate the gate lane by lane between the two register stages
   always_comb begin
      f = '0;
      for (int i = 0; i < LANES; i++) begin
         f[i] = mg_f(s1_a[i], s1_b[i], s1_c[i], s1_d[i]);
      end
   end

   mg_pipe_stage #(.W(LANES+1)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (s2_adv),
      .in_valid  (s1_valid),
      .in_data   ({|f, f}),
      .out_valid (s2_valid),
      .out_data  (s2_data)
   );

   assign y         = s2_data[LANES-1:0];
   assign any_hit   = s2_data[LANES];
   assign out_valid = s2_valid;

`ifdef TOGGLE_CNT_EN
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_max(CNT_W));

   logic             out_hs;
   logic [6:0]       toggles;
   logic [CNT_W:0]   cnt_sum;
   logic [LANES-1:0] y_prev_d, y_prev_q;
   logic [CNT_W-1:0] cnt_d,    cnt_q;

   assign out_hs  = out_valid & out_ready;
   assign toggles = popcount(64'(y ^ y_prev_q));
   assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(toggles);

   // Accumulate toggles per output beat, saturating; a clear always wins
   always_comb begin
      y_prev_d = y_prev_q;
      cnt_d    = cnt_q;
      if (out_hs) begin
         y_prev_d = y;
         cnt_d    = cnt_sum[CNT_W] ? CNT_SAT : cnt_sum[CNT_W-1:0];
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end
   end

   // Counter and previous-beat registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_prev_q <= '0;
         cnt_q    <= '0;
      end else begin
         y_prev_q <= y_prev_d;
         cnt_q    <= cnt_d;
      end
   end

   assign toggle_cnt = cnt_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign toggle_cnt     = '0;
`endif

endmodule
